// File: rtl/arb4_rr_sar_pkg.sv
// Shared definitions for the four-way round-robin arbiter in front of mux4_to_1_sar.
package arb_sar_defs;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux4_to_1_sar.sv
// One-bit 4-to-1 selector; {s1,s0} picks i0..i3.
module mux4_to_1_sar (
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic s1,
   input  logic s0,
   output logic y
);

   // select one of four inputs
   always_comb begin
      y = 1'b0;
      case ({s1, s0})
         2'b00:   y = i0;
         2'b01:   y = i1;
         2'b10:   y = i2;
         2'b11:   y = i3;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/rr_pick4_sar.sv
// Round-robin priority pick: first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4_sar
   import arb_sar_defs::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   winner,
   output logic               any
);

   logic [2*NUM_REQ-1:0] dbl_s;
   logic [NUM_REQ-1:0]   rot_s;
   logic [SEL_W-1:0]     off_s;

   // rotate so ptr sits at bit 0, then take the lowest set bit
   always_comb begin
      dbl_s = {req, req} >> ptr;
      rot_s = dbl_s[NUM_REQ-1:0];
      off_s = 2'd0;
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
      winner = ptr + off_s;
      any    = |req;
   end

endmodule

// File: rtl/arb4_rr_sar.sv
// Round-robin arbiter/sequencer sharing one mux4_to_1_sar datapath between four requesters.
module arb4_rr_sar
   import arb_sar_defs::*;
#(
   parameter int DATA_W   = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   in_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [SEL_W-1:0]            sel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic                        busy
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t           state_r;
   logic [SEL_W-1:0] ptr_r;
   logic [3:0]       hold_cnt_r;
   logic [SEL_W-1:0] winner_s;
   logic             any_s;
   logic             xfer_s;
   logic             release_s;

   rr_pick4_sar u_pick (
      .req    (req),
      .ptr    (ptr_r),
      .winner (winner_s),
      .any    (any_s)
   );

   // handshake and release decision for the current owner
   always_comb begin
      out_valid = 1'b0;
      if (state_r == ST_GRANT) begin
         out_valid = req[sel];
      end else begin
         out_valid = 1'b0;
      end
      xfer_s    = out_valid & out_ready;
      release_s = (state_r == ST_GRANT) &&
                  (!req[sel] || (xfer_s && (hold_cnt_r == HOLD_LAST)));
   end

   assign busy = (state_r == ST_GRANT);

   // arbitration FSM with registered grant and select
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         gnt        <= 4'b0000;
         sel        <= 2'b00;
         ptr_r      <= 2'b00;
         hold_cnt_r <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  state_r    <= ST_GRANT;
                  gnt        <= onehot(winner_s);
                  sel        <= winner_s;
                  hold_cnt_r <= 4'd0;
               end else begin
                  gnt        <= 4'b0000;
               end
            end
            ST_GRANT: begin
               if (release_s) begin
                  state_r    <= ST_IDLE;
                  gnt        <= 4'b0000;
                  ptr_r      <= sel + 2'd1;
                  hold_cnt_r <= 4'd0;
               end else if (xfer_s) begin
                  hold_cnt_r <= hold_cnt_r + 4'd1;
               end else begin
                  hold_cnt_r <= hold_cnt_r;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               gnt        <= 4'b0000;
               hold_cnt_r <= 4'd0;
            end
         endcase
      end
   end

   // one mux4_to_1_sar per data bit
   for (genvar b = 0; b < DATA_W; b++) begin : g_lane
      mux4_to_1_sar u_mux (
         .i0 (in_data[0*DATA_W + b]),
         .i1 (in_data[1*DATA_W + b]),
         .i2 (in_data[2*DATA_W + b]),
         .i3 (in_data[3*DATA_W + b]),
         .s1 (sel[1]),
         .s0 (sel[0]),
         .y  (out_data[b])
      );
   end

endmodule

// File: tb/tb_arb4_rr_sar.sv
// Self-checking bench for arb4_rr_sar: cycle model plus directed literal checks.
module tb_arb4_rr_sar;

   localparam int DW = 1;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [4*DW-1:0] in_data;
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: owner, transfers so far, scan start
   bit m_busy = 1'b0;
   int m_sel  = 0;
   int m_ptr  = 0;
   int m_cnt  = 0;

   int glog[$];
   int xcnt[$];
   int dlog[$];
   bit prev_busy = 1'b0;

   arb4_rr_sar #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data   (in_data),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // behavioural model: who owns the mux and how many transfers it has had
   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < 4; k++) begin
            if (!m_busy && req[(m_ptr + k) % 4]) begin
               m_busy = 1'b1; m_sel = (m_ptr + k) % 4; m_cnt = 0;
            end
         end
      end else if (!req[m_sel]) begin
         m_busy = 1'b0; m_ptr = (m_sel + 1) % 4; m_cnt = 0;
      end else if (out_ready) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == MH) begin
            m_busy = 1'b0; m_ptr = (m_sel + 1) % 4; m_cnt = 0;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0000; in_data = 4'b0101; out_ready = 1'b0;
      fork
         // per-cycle compare against the model, plus grant/transfer logging
         forever begin
            @(negedge clk);
            chk("gnt",  int'(gnt),  m_busy ? (1 << m_sel) : 0);
            chk("sel",  int'(sel),  m_sel);
            chk("busy", int'(busy), int'(m_busy));
            chk("out_valid", int'(out_valid), int'(m_busy && req[m_sel]));
            if (m_busy && req[m_sel])
               chk("out_data", int'(out_data), int'(in_data[m_sel*DW +: DW]));
            if (busy && !prev_busy) begin
               glog.push_back(int'(sel));
               xcnt.push_back(0);
               dlog.push_back(-1);
            end
            if (busy && out_valid && out_ready && xcnt.size() > 0) begin
               if (xcnt[xcnt.size()-1] == 0) dlog[dlog.size()-1] = int'(out_data);
               xcnt[xcnt.size()-1] = xcnt[xcnt.size()-1] + 1;
            end
            prev_busy = busy;
         end
         begin
            tick(2);
            #1;
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_valid", int'(out_valid), 0);
            rst_n = 1'b1;
            tick(1);

            // single requester: 4 transfers, bubble, re-grant
            glog.delete(); xcnt.delete(); dlog.delete();
            req = 4'b0001; out_ready = 1'b1;
            tick(1); #1;
            chk("single_latency_gnt", int'(gnt), 1);
            chk("single_sel", int'(sel), 0);
            tick(7);
            chk("single_grants", glog.size(), 2);
            if (glog.size() >= 2) begin
               chk("single_g0", glog[0], 0);
               chk("single_g1", glog[1], 0);
               chk("single_xfers", xcnt[0], 4);
            end
            req = 4'b0000;
            tick(3);

            // round robin with data steering
            pulse_reset();
            glog.delete(); xcnt.delete(); dlog.delete();
            req = 4'b1111; out_ready = 1'b1; in_data = 4'b0101;
            tick(23);
            chk("rr_grants", glog.size(), 5);
            if (glog.size() == 5) begin
               chk("rr_g0", glog[0], 0);
               chk("rr_g1", glog[1], 1);
               chk("rr_g2", glog[2], 2);
               chk("rr_g3", glog[3], 3);
               chk("rr_g4_wrap", glog[4], 0);
               for (int i = 0; i < 4; i++) chk("rr_xfers", xcnt[i], 4);
               chk("steer_d0", dlog[0], 1);
               chk("steer_d1", dlog[1], 0);
               chk("steer_d2", dlog[2], 1);
               chk("steer_d3", dlog[3], 0);
            end

            // backpressure then withdraw
            pulse_reset();
            req = 4'b0100; out_ready = 1'b0;
            tick(6); #1;
            chk("bp_gnt", int'(gnt), 4);
            chk("bp_sel", int'(sel), 2);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_busy", int'(busy), 1);
            req = 4'b0000; #1;
            chk("wd_valid", int'(out_valid), 0);
            chk("wd_gnt_held", int'(gnt), 4);
            tick(1); #1;
            chk("wd_gnt_next", int'(gnt), 0);
            chk("wd_busy_next", int'(busy), 0);
            req = 4'b1001;
            tick(1); #1;
            chk("ptr3_winner", int'(sel), 3);
            req = 4'b0000; tick(2);
            req = 4'b0001; tick(1); #1;
            chk("ptr0_winner", int'(sel), 0);
            req = 4'b0000; tick(2);
            req = 4'b0001; tick(1); #1;
            chk("skip_wrap_winner", int'(sel), 0);
            req = 4'b0000; tick(2);
            req = 4'b1001; tick(1); #1;
            chk("skip_winner3", int'(sel), 3);
            req = 4'b0000; tick(2);

            // reset in the middle of a grant
            pulse_reset();
            req = 4'b1111; out_ready = 1'b1;
            tick(3);
            rst_n = 1'b0;
            tick(1); #1;
            chk("midrst_gnt", int'(gnt), 0);
            chk("midrst_sel", int'(sel), 0);
            chk("midrst_valid", int'(out_valid), 0);
            chk("midrst_busy", int'(busy), 0);
            rst_n = 1'b1; req = 4'b0110;
            tick(1); #1;
            chk("midrst_regrant_sel", int'(sel), 1);
            chk("midrst_regrant_gnt", int'(gnt), 2);
            tick(3);
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/arb4_rr_sar.md
Name: arb4_rr_sar

Overview:
Round-robin arbiter and sequencer that shares one 4-to-1 selector datapath between four requesters.
- Picks one requester, drives its select code (S1,S0) onto the mux, and streams that requester's data out through a valid/ready handshake.
- Releases the mux when the requester drops its request or uses up its hold quota.
- Sits directly in front of the existing mux4_to_1_sar datapath.

Parameters:
DATA_W, 1, width of each requester's data lane (one mux4_to_1_sar per bit)
MAX_HOLD, 4, max accepted transfers per grant before forced release (1..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req  input  4  request per requester, level-held until served or withdrawn
in_data  input  4*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
gnt  output  4  one-hot grant, registered
sel  output  2  mux select {S1,S0} = index of current owner, registered
out_valid  output  1  out_data is valid this cycle
out_ready  input  1  downstream accepts out_data
out_data  output  DATA_W  mux output = in_data lane[sel]
busy  output  1  state == GRANT

Behaviour:
- Reset (rst_n low at a rising clk):
  - state=IDLE, gnt=4'b0000, sel=2'b00, ptr=2'b00, hold_cnt=0, out_valid=0, busy=0.
  - Reset mid-grant aborts the grant with no transfer in that cycle.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: state=GRANT, gnt=onehot(winner), sel=winner, hold_cnt=0.
  - Grant latency: one cycle from req sampled to gnt asserted.
  - If req == 0, stay in IDLE and hold all outputs at reset values (sel keeps its last value).
- GRANT:
  - out_valid = req[sel] (combinational from state, sel, req).
  - out_data is combinational through the mux lanes; it is valid only when out_valid=1.
  - Transfer = out_valid && out_ready. Each transfer increments hold_cnt (4-bit).
  - Release when req[sel]==0 (withdrawn), or when a transfer occurs with hold_cnt == MAX_HOLD-1.
  - On release, next cycle: state=IDLE, gnt=0, ptr=sel+1 (mod 4, wraps 3->0), hold_cnt=0.
  - There is always exactly one IDLE bubble cycle between successive grants.
- Simultaneous events:
  - Withdraw and a transfer cannot coincide, because out_valid=0 when req[sel]=0.
  - New requests arriving during GRANT are ignored until IDLE.
  - out_ready held high gives exactly MAX_HOLD transfers, on consecutive cycles.
- Fairness: a requester that is continuously requesting is granted within 3 grants of any other requester.
- gnt is always one-hot or zero; sel always equals the index of gnt's set bit when gnt != 0.
- out_ready is ignored outside GRANT.

Decomposition:
- Shared package/header (arb_sar_defs): state encodings ST_IDLE=1'b0, ST_GRANT=1'b1; constant NUM_REQ=4; SEL_W=2.
- Datapath: DATA_W instances of the existing mux4_to_1_sar, generated per bit, with S1=sel[1] and S0=sel[0].
- The round-robin priority pick is a natural pure-combinational sub-module: rr_pick4_sar (inputs req, ptr; outputs winner[1:0], any).

Test Plan:
- Reset then single requester: req=4'b0001, out_ready=1, MAX_HOLD=4, DATA_W=1 -> gnt=0001 one cycle after req; sel=00; 4 consecutive transfers; then one IDLE cycle; then re-granted to requester 0 (only requester); ptr=01.
- Round-robin: req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0; each grant lasts 4 cycles with a 1-cycle gap; sel sequence 00,01,10,11,00 (wrap 3->0 checked).
- Data steering: in_data=4'b0101 (IN0=1, IN1=0, IN2=1, IN3=0), grant each requester in turn -> out_data = 1,0,1,0 for sel = 00,01,10,11.
- Backpressure and withdraw: requester 2 granted, out_ready=0 for 5 cycles -> out_valid=1, hold_cnt=0, grant held. Then req[2] drops -> out_valid=0 that cycle, gnt=0 next cycle, ptr=11.
- Skip idle requesters: ptr=01, req=4'b0001 -> winner 0 (wrap). With req=4'b1001 and ptr=01 -> winner 3.
- Reset mid-operation: assert rst_n=0 during GRANT with hold_cnt=2 -> next cycle gnt=0, sel=00, out_valid=0, ptr=00, busy=0; after release, req=4'b0110 -> grant to 1 first.
